// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a doubleword-wide synchronous data memory.
// Extends load lanes, merges sub-doubleword stores (read-modify-write), and pulses a response.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_type,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_error,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  // READ is the first latency cycle, so WAIT only covers the remaining MEM_LATENCY-1.
  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t      state, next_state;
  logic        is_store_q;
  logic [2:0]  type_q;
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic        err_q;
  logic [3:0]  cnt_q;

  // Access size in bytes; 0 marks a reserved code.
  function automatic logic [3:0] size_of(input logic st, input logic [2:0] ty);
    logic [3:0] sz;
    sz = 4'd0;
    if (st) begin
      case (ty)
        3'd1: sz = 4'd8;
        3'd2: sz = 4'd4;
        3'd3: sz = 4'd2;
        3'd4: sz = 4'd1;
        default: sz = 4'd0;
      endcase
    end else begin
      case (ty)
        3'd1:       sz = 4'd8;
        3'd2, 3'd5: sz = 4'd4;
        3'd3, 3'd6: sz = 4'd2;
        3'd4, 3'd7: sz = 4'd1;
        default:    sz = 4'd0;
      endcase
    end
    return sz;
  endfunction

  logic [3:0]  req_size, lat_size;
  logic        req_err, req_is_sd, capture;
  logic [5:0]  shamt;
  logic [63:0] lane, load_ext, size_mask, merged;

  always_comb begin
    req_size = size_of(req_is_store, req_type);
    case (req_size)
      4'd8:    req_err = (req_addr[2:0] != 3'd0);
      4'd4:    req_err = (req_addr[1:0] != 2'd0);
      4'd2:    req_err = req_addr[0];
      4'd1:    req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
    req_is_sd = req_is_store && (req_type == 3'd1);
  end

  assign capture = ((state == READ) && (MEM_LATENCY == 1)) ||
                   ((state == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    lat_size = size_of(is_store_q, type_q);
    shamt    = {addr_q[2:0], 3'b000};
    lane     = mem_rdata >> shamt;
    case (type_q)
      3'd2:    load_ext = {{32{lane[31]}}, lane[31:0]};
      3'd3:    load_ext = {{48{lane[15]}}, lane[15:0]};
      3'd4:    load_ext = {{56{lane[7]}},  lane[7:0]};
      3'd5:    load_ext = {32'd0, lane[31:0]};
      3'd6:    load_ext = {48'd0, lane[15:0]};
      3'd7:    load_ext = {56'd0, lane[7:0]};
      default: load_ext = mem_rdata;
    endcase
    case (lat_size)
      4'd8:    size_mask = {64{1'b1}};
      4'd4:    size_mask = 64'h0000_0000_FFFF_FFFF;
      4'd2:    size_mask = 64'h0000_0000_0000_FFFF;
      default: size_mask = 64'h0000_0000_0000_00FF;
    endcase
    merged = (mem_rdata & ~(size_mask << shamt)) | ((data_q & size_mask) << shamt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)        next_state = RESP;
          else if (req_is_sd) next_state = WRITE;
          else                next_state = READ;
        end
      end
      READ, WAIT: begin
        if (capture)            next_state = is_store_q ? WRITE : RESP;
        else if (state == READ) next_state = WAIT;
      end
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_store_q <= 1'b0;
      type_q     <= 3'd0;
      addr_q     <= 64'd0;
      data_q     <= 64'd0;
      err_q      <= 1'b0;
      cnt_q      <= 4'd0;
      resp_data  <= 64'd0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        is_store_q <= req_is_store;
        type_q     <= req_type;
        addr_q     <= req_addr;
        data_q     <= req_wdata;
        err_q      <= req_err;
      end
      if (state == READ) cnt_q <= CNT_INIT;
      else if ((state == WAIT) && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
      if (capture) begin
        if (is_store_q) data_q    <= merged;
        else            resp_data <= load_ext;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = ~req_ready;
  assign mem_rd     = (state == READ);
  assign mem_wr     = (state == WRITE);
  assign mem_addr   = (state != IDLE) ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_wdata  = (state == WRITE) ? data_q : 64'd0;
  assign resp_valid = (state == RESP);
  assign resp_error = (state == RESP) && err_q;

endmodule
